// File: rtl/data_memory_lsu_if.sv
// Request/response channel between the MEM stage and the data-memory LSU.
// Signal names are as seen from the LSU (slave) side.
interface data_memory_lsu_if #(
  parameter int unsigned DATAWIDTH = 32,
  parameter int unsigned ADDRWIDTH = 14
);
  logic                 req_valid_i;
  logic                 req_ready_o;
  logic                 req_we_i;
  logic [ADDRWIDTH-1:0] req_addr_i;
  logic [2:0]           req_funct3_i;
  logic [DATAWIDTH-1:0] req_wdata_i;
  logic                 rsp_valid_o;
  logic                 rsp_ready_i;
  logic [DATAWIDTH-1:0] rsp_rdata_o;
  logic                 rsp_err_o;
  logic                 busy_o;

  modport master (
    output req_valid_i, req_we_i, req_addr_i, req_funct3_i, req_wdata_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, busy_o
  );

  modport slave (
    input  req_valid_i, req_we_i, req_addr_i, req_funct3_i, req_wdata_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, busy_o
  );
endinterface

// File: rtl/data_memory_lsu.sv
// RV data memory with load/store front end: sized, byte-lane writes, extended loads,
// alignment checking, valid/ready channels and a post-reset zero-clear sweep.
module data_memory_lsu #(
  parameter int unsigned DATAWIDTH      = 32,
  parameter int unsigned ADDRWIDTH      = 14,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  data_memory_lsu_if.slave   lsu
);

  localparam int unsigned NB    = DATAWIDTH / 8;
  localparam int unsigned LSB   = (DATAWIDTH == 64) ? 3 : 2;
  localparam int unsigned IW    = ADDRWIDTH - LSB;
  localparam int unsigned WORDS = 1 << IW;
  localparam bit          IS64  = (DATAWIDTH == 64);

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_RESP} state_t;
  localparam state_t RST_STATE = CLEAR_ON_RESET ? S_CLEAR : S_IDLE;

  logic [DATAWIDTH-1:0] r_mem [WORDS];

  state_t               r_state, w_next;
  logic [IW-1:0]        r_cnt;
  logic                 r_rsp_valid;
  logic                 r_err;
  logic                 r_load_ok;
  logic [DATAWIDTH-1:0] r_raw;
  logic [LSB-1:0]       r_lane;
  logic [2:0]           r_funct3;

  logic                 w_ready, w_busy, w_clear_we, w_hs, w_last, w_legal, w_store_we;
  logic [IW-1:0]        w_idx;
  logic [LSB-1:0]       w_lane;
  logic [NB-1:0]        w_be;
  logic [DATAWIDTH-1:0] w_wdata_sh, w_shift, w_fmt;

  assign w_idx      = lsu.req_addr_i[ADDRWIDTH-1:LSB];
  assign w_lane     = lsu.req_addr_i[LSB-1:0];
  assign w_hs       = lsu.req_valid_i & w_ready;
  assign w_last     = (r_cnt == IW'(WORDS - 1));
  assign w_store_we = w_hs & lsu.req_we_i & w_legal;
  assign w_wdata_sh = lsu.req_wdata_i << {w_lane, 3'b000};

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= RST_STATE;
    else         r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_CLEAR: if (w_last) w_next = S_IDLE;
      S_IDLE:  if (w_hs) w_next = S_RESP;
      S_RESP:  if (lsu.rsp_ready_i && !w_hs) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State-decoded controls
  always_comb begin
    w_ready    = 1'b0;
    w_busy     = 1'b0;
    w_clear_we = 1'b0;
    case (r_state)
      S_CLEAR: begin
        w_busy     = 1'b1;
        w_clear_we = 1'b1;
      end
      S_IDLE:  w_ready = 1'b1;
      S_RESP:  w_ready = lsu.rsp_ready_i;
      default: w_ready = 1'b0;
    endcase
  end

  // Size/alignment legality and byte enables at the addressed lane
  always_comb begin
    w_legal = 1'b0;
    w_be    = '0;
    case (lsu.req_funct3_i)
      3'b000, 3'b100: begin
        w_legal = 1'b1;
        w_be    = NB'(1) << w_lane;
      end
      3'b001, 3'b101: begin
        w_legal = ~lsu.req_addr_i[0];
        w_be    = NB'(2'b11) << w_lane;
      end
      3'b010: begin
        w_legal = (lsu.req_addr_i[1:0] == 2'b00);
        w_be    = NB'(4'hF) << w_lane;
      end
      3'b011: begin
        w_legal = IS64 && (lsu.req_addr_i[2:0] == 3'b000);
        w_be    = NB'(8'hFF) << w_lane;
      end
      3'b110: begin
        w_legal = IS64 && (lsu.req_addr_i[1:0] == 2'b00);
        w_be    = NB'(4'hF) << w_lane;
      end
      default: begin
        w_legal = 1'b0;
        w_be    = '0;
      end
    endcase
  end

  // Memory array: clear sweep has priority; stores write only enabled lanes
  always_ff @(posedge clk_i) begin
    if (w_clear_we) begin
      r_mem[r_cnt] <= '0;
    end else if (w_store_we) begin
      for (int b = 0; b < int'(NB); b++) begin
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata_sh[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_cnt <= '0;
    else if (w_clear_we) r_cnt <= IW'(r_cnt + 1'b1);
  end

  // Response capture; fields only change on a new handshake so a stalled response stays stable
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rsp_valid <= 1'b0;
      r_err       <= 1'b0;
      r_load_ok   <= 1'b0;
      r_raw       <= '0;
      r_lane      <= '0;
      r_funct3    <= '0;
    end else if (w_hs) begin
      r_rsp_valid <= 1'b1;
      r_err       <= ~w_legal;
      r_load_ok   <= w_legal & ~lsu.req_we_i;
      r_raw       <= r_mem[w_idx];
      r_lane      <= w_lane;
      r_funct3    <= lsu.req_funct3_i;
    end else if (lsu.rsp_ready_i) begin
      r_rsp_valid <= 1'b0;
    end
  end

  // Load alignment and extension
  assign w_shift = r_raw >> {r_lane, 3'b000};
  always_comb begin
    w_fmt = w_shift;
    case (r_funct3)
      3'b000:  w_fmt = DATAWIDTH'($signed(w_shift[7:0]));
      3'b100:  w_fmt = DATAWIDTH'(w_shift[7:0]);
      3'b001:  w_fmt = DATAWIDTH'($signed(w_shift[15:0]));
      3'b101:  w_fmt = DATAWIDTH'(w_shift[15:0]);
      3'b010:  w_fmt = DATAWIDTH'($signed(w_shift[31:0]));
      3'b110:  w_fmt = DATAWIDTH'(w_shift[31:0]);
      default: w_fmt = w_shift;
    endcase
  end

  assign lsu.req_ready_o = w_ready;
  assign lsu.busy_o      = w_busy;
  assign lsu.rsp_valid_o = r_rsp_valid;
  assign lsu.rsp_err_o   = r_err;
  assign lsu.rsp_rdata_o = r_load_ok ? w_fmt : '0;

endmodule

// File: tb/tb_data_memory_lsu.sv
// Directed bench for data_memory_lsu (32-bit data, 12-bit address, clear on reset).
module tb_data_memory_lsu;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  int   n_cmp  = 0;
  int   n_mis  = 0;

  always #5 clk_i = ~clk_i;

  data_memory_lsu_if #(.DATAWIDTH(32), .ADDRWIDTH(12)) lsu ();

  data_memory_lsu #(
    .DATAWIDTH(32), .ADDRWIDTH(12), .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .lsu    (lsu)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Count busy cycles from reset release until the sweep ends
  task automatic sweep(input string tag);
    int n = 0;
    chk({tag, "_rdy0"}, 32'(lsu.req_ready_o), 32'd0);
    while (lsu.busy_o && n < 2000) begin
      n++;
      @(posedge clk_i); #1;
    end
    chk({tag, "_cycles"}, 32'(n), 32'd1024);
    chk({tag, "_rdy1"}, 32'(lsu.req_ready_o), 32'd1);
  endtask

  // One request with rsp_ready high; called 1 time unit after a rising edge
  task automatic xfer(input string tag, input bit we, input logic [11:0] addr, input logic [2:0] f3,
                      input logic [31:0] wd, input logic [31:0] exp_rd, input bit exp_err);
    int n = 0;
    lsu.req_valid_i  = 1'b1;
    lsu.req_we_i     = we;
    lsu.req_addr_i   = addr;
    lsu.req_funct3_i = f3;
    lsu.req_wdata_i  = wd;
    lsu.rsp_ready_i  = 1'b1;
    while (!lsu.req_ready_o && n < 20) begin
      n++;
      @(posedge clk_i); #1;
    end
    if (!lsu.req_ready_o) chk({tag, "_rdy_timeout"}, 32'd0, 32'd1);
    @(posedge clk_i); #1;
    lsu.req_valid_i = 1'b0;
    chk({tag, "_vld"}, 32'(lsu.rsp_valid_o), 32'd1);
    chk({tag, "_data"}, lsu.rsp_rdata_o, exp_rd);
    chk({tag, "_err"}, 32'(lsu.rsp_err_o), 32'(exp_err));
    @(posedge clk_i); #1;
  endtask

  logic [31:0] held;

  initial begin
    lsu.req_valid_i  = 1'b0;
    lsu.req_we_i     = 1'b0;
    lsu.req_addr_i   = '0;
    lsu.req_funct3_i = 3'b010;
    lsu.req_wdata_i  = '0;
    lsu.rsp_ready_i  = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_vld", 32'(lsu.rsp_valid_o), 32'd0);
    chk("rst_data", lsu.rsp_rdata_o, 32'd0);
    chk("rst_err", 32'(lsu.rsp_err_o), 32'd0);
    chk("rst_busy", 32'(lsu.busy_o), 32'd1);
    rst_ni = 1'b1;
    sweep("clr1");
    xfer("lw_7fc", 1'b0, 12'h7FC, 3'b010, 32'h0, 32'h0, 1'b0);

    // Sized loads of a stored word
    xfer("sw_10", 1'b1, 12'h010, 3'b010, 32'hDEADBEEF, 32'h0, 1'b0);
    xfer("lb_13", 1'b0, 12'h013, 3'b000, 32'h0, 32'hFFFFFFDE, 1'b0);
    xfer("lbu_13", 1'b0, 12'h013, 3'b100, 32'h0, 32'h000000DE, 1'b0);
    xfer("lh_12", 1'b0, 12'h012, 3'b001, 32'h0, 32'hFFFFDEAD, 1'b0);
    xfer("lhu_10", 1'b0, 12'h010, 3'b101, 32'h0, 32'h0000BEEF, 1'b0);
    xfer("lb_10", 1'b0, 12'h010, 3'b000, 32'h0, 32'hFFFFFFEF, 1'b0);

    // Partial stores
    xfer("sb_11", 1'b1, 12'h011, 3'b000, 32'h0000007F, 32'h0, 1'b0);
    xfer("lw_sb", 1'b0, 12'h010, 3'b010, 32'h0, 32'hDEAD7FEF, 1'b0);
    xfer("sh_12", 1'b1, 12'h012, 3'b001, 32'h00001234, 32'h0, 1'b0);
    xfer("lw_sh", 1'b0, 12'h010, 3'b010, 32'h0, 32'h12347FEF, 1'b0);

    // Illegal accesses
    xfer("lw_mis", 1'b0, 12'h012, 3'b010, 32'h0, 32'h0, 1'b1);
    xfer("sh_mis", 1'b1, 12'h011, 3'b001, 32'hFFFFFFFF, 32'h0, 1'b1);
    xfer("lw_keep", 1'b0, 12'h010, 3'b010, 32'h0, 32'h12347FEF, 1'b0);
    xfer("ld_32", 1'b0, 12'h010, 3'b011, 32'h0, 32'h0, 1'b1);
    xfer("lwu_32", 1'b0, 12'h010, 3'b110, 32'h0, 32'h0, 1'b1);
    xfer("f3_111", 1'b0, 12'h010, 3'b111, 32'h0, 32'h0, 1'b1);

    // Response stall
    lsu.req_valid_i  = 1'b1;
    lsu.req_we_i     = 1'b0;
    lsu.req_addr_i   = 12'h010;
    lsu.req_funct3_i = 3'b010;
    lsu.rsp_ready_i  = 1'b0;
    @(posedge clk_i); #1;
    lsu.req_valid_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("stall_vld", 32'(lsu.rsp_valid_o), 32'd1);
      chk("stall_data", lsu.rsp_rdata_o, 32'h12347FEF);
      chk("stall_rdy", 32'(lsu.req_ready_o), 32'd0);
      @(posedge clk_i); #1;
    end
    lsu.rsp_ready_i = 1'b1;
    @(posedge clk_i); #1;
    chk("stall_done", 32'(lsu.rsp_valid_o), 32'd0);

    // Back-to-back loads
    for (int k = 0; k < 8; k++)
      xfer("pre_sw", 1'b1, 12'(12'h020 + 4 * k), 3'b010, 32'hA5000000 | 32'(k), 32'h0, 1'b0);
    for (int k = 0; k <= 8; k++) begin
      if (k > 0) begin
        chk("b2b_vld", 32'(lsu.rsp_valid_o), 32'd1);
        chk("b2b_data", lsu.rsp_rdata_o, 32'hA5000000 | 32'(k - 1));
      end
      if (k < 8) begin
        lsu.req_valid_i  = 1'b1;
        lsu.req_we_i     = 1'b0;
        lsu.req_addr_i   = 12'(12'h020 + 4 * k);
        lsu.req_funct3_i = 3'b010;
        chk("b2b_rdy", 32'(lsu.req_ready_o), 32'd1);
      end else begin
        lsu.req_valid_i = 1'b0;
      end
      @(posedge clk_i); #1;
    end
    chk("b2b_end", 32'(lsu.rsp_valid_o), 32'd0);

    // Reset during a pending response
    xfer("sw_0", 1'b1, 12'h000, 3'b010, 32'h11223344, 32'h0, 1'b0);
    xfer("sw_7fc", 1'b1, 12'h7FC, 3'b010, 32'h55667788, 32'h0, 1'b0);
    lsu.req_valid_i  = 1'b1;
    lsu.req_we_i     = 1'b0;
    lsu.req_addr_i   = 12'h000;
    lsu.req_funct3_i = 3'b010;
    lsu.rsp_ready_i  = 1'b0;
    @(posedge clk_i); #1;
    lsu.req_valid_i = 1'b0;
    chk("pre_rst_vld", 32'(lsu.rsp_valid_o), 32'd1);
    chk("pre_rst_data", lsu.rsp_rdata_o, 32'h11223344);
    #2 rst_ni = 1'b0;
    #1;
    chk("mid_rst_vld", 32'(lsu.rsp_valid_o), 32'd0);
    chk("mid_rst_busy", 32'(lsu.busy_o), 32'd1);
    held = lsu.rsp_rdata_o;
    chk("mid_rst_data", held, 32'd0);
    lsu.rsp_ready_i = 1'b1;
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    sweep("clr2");
    xfer("lw_0_clr", 1'b0, 12'h000, 3'b010, 32'h0, 32'h0, 1'b0);
    xfer("lw_7fc_clr", 1'b0, 12'h7FC, 3'b010, 32'h0, 32'h0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
